// File: rtl/testchip_testclk_pkg.sv
// +--------------------------------------------------------------------+
// | testchip_testclk_pkg : states and select codes for test-clk ctrl   |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

package testchip_testclk_pkg;

  localparam int TCLK_CNT_W = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DRAIN  = 2'd1,
    SETTLE = 2'd2
  } tclk_state_e;

  localparam logic [3:0] TCLK_SEL_PAM3 = 4'b0000;
  localparam logic [3:0] TCLK_SEL_UC   = 4'b0001;
  localparam logic [3:0] TCLK_SEL_REF0 = 4'b0010;
  localparam logic [3:0] TCLK_SEL_REF1 = 4'b0011;
  localparam logic [3:0] TCLK_SEL_AUX0 = 4'b0100;
  localparam logic [3:0] TCLK_SEL_AUX1 = 4'b0101;
  localparam logic [3:0] TCLK_SEL_NOC  = 4'b0110;
  localparam logic [3:0] TCLK_SEL_CDB  = 4'b0111;
  localparam logic [3:0] TCLK_SEL_PHY  = 4'b1000;

endpackage

`default_nettype wire

// File: rtl/testchip_testclk_ctrl.sv
// +--------------------------------------------------------------------+
// | testchip_testclk_ctrl : gate-off / drain / switch / settle / gate  |
// | sequencer for the test-clock select stage.            Rev 1.0      |
// +--------------------------------------------------------------------+
`default_nettype none

module testchip_testclk_ctrl
  import testchip_testclk_pkg::*;
#(
  parameter int DRAIN_CYCLES  = 16,
  parameter int SETTLE_CYCLES = 32
) (
  input  logic       uc_clk,
  input  logic       reset_n,
  input  logic       cfg_req,
  input  logic [3:0] cfg_sel,
  input  logic       cfg_en,
  output logic       cfg_busy,
  output logic       cfg_done,
  output logic       cfg_drop,
  output logic [3:0] test_clk_sel,
  output logic       test_clk_en
);

  if (DRAIN_CYCLES < 1 || DRAIN_CYCLES > 255) begin : g_drain_range_err
    $error("testchip_testclk_ctrl: DRAIN_CYCLES must be 1..255");
  end
  if (SETTLE_CYCLES < 1 || SETTLE_CYCLES > 255) begin : g_settle_range_err
    $error("testchip_testclk_ctrl: SETTLE_CYCLES must be 1..255");
  end

  localparam logic [TCLK_CNT_W-1:0] DRAIN_LOAD  = TCLK_CNT_W'(DRAIN_CYCLES - 1);
  localparam logic [TCLK_CNT_W-1:0] SETTLE_LOAD = TCLK_CNT_W'(SETTLE_CYCLES - 1);

  tclk_state_e           state_q, state_d;
  logic [TCLK_CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]            shadow_sel_q, shadow_sel_d;
  logic                  shadow_en_q, shadow_en_d;
  logic [3:0]            sel_q, sel_d;
  logic                  en_q, en_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  drop_q, drop_d;

  always_ff @(posedge uc_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      shadow_sel_q <= '0;
      shadow_en_q  <= 1'b0;
      sel_q        <= TCLK_SEL_PAM3;
      en_q         <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      drop_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      shadow_sel_q <= shadow_sel_d;
      shadow_en_q  <= shadow_en_d;
      sel_q        <= sel_d;
      en_q         <= en_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      drop_q       <= drop_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    shadow_sel_d = shadow_sel_q;
    shadow_en_d  = shadow_en_q;
    sel_d        = sel_q;
    en_d         = en_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    drop_d       = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (cfg_req) begin
          shadow_sel_d = cfg_sel;
          shadow_en_d  = cfg_en;
          if (cfg_sel == sel_q) begin
            en_d   = cfg_en;
            done_d = 1'b1;
          end else begin
            en_d    = 1'b0;
            busy_d  = 1'b1;
            state_d = DRAIN;
            cnt_d   = DRAIN_LOAD;
          end
        end
      end

      DRAIN: begin
        drop_d = cfg_req;
        if (cnt_q == '0) begin
          state_d = SETTLE;
          sel_d   = shadow_sel_q;
          cnt_d   = SETTLE_LOAD;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end

      SETTLE: begin
        drop_d = cfg_req;
        if (cnt_q == '0) begin
          state_d = IDLE;
          en_d    = shadow_en_q;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          // Request on the exit cycle is still discarded; done wins the pulse slot.
          drop_d  = 1'b0;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end

      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
        en_d    = 1'b0;
      end
    endcase
  end

  assign cfg_busy     = busy_q;
  assign cfg_done     = done_q;
  assign cfg_drop     = drop_q;
  assign test_clk_sel = sel_q;
  assign test_clk_en  = en_q;

endmodule

`default_nettype wire

// File: tb/tb_testchip_testclk_ctrl.sv
// +--------------------------------------------------------------------+
// | tb_testchip_testclk_ctrl : directed bench for the test-clk ctrl    |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

module tb_testchip_testclk_ctrl;

  logic       uc_clk;
  logic       reset_n;
  logic       cfg_req;
  logic [3:0] cfg_sel;
  logic       cfg_en;
  logic       cfg_busy, cfg_done, cfg_drop;
  logic [3:0] test_clk_sel;
  logic       test_clk_en;

  logic       req2;
  logic [3:0] sel2;
  logic       en2;
  logic       busy2, done2, drop2;
  logic [3:0] tsel2;
  logic       ten2;

  int n_checks;
  int n_errors;
  int viol;
  int mon_dones;
  logic       mon_on;
  logic [3:0] prev_sel, prev_sel2;
  logic       prev_en, prev_en2;

  testchip_testclk_ctrl u_dut (
    .uc_clk       (uc_clk),
    .reset_n      (reset_n),
    .cfg_req      (cfg_req),
    .cfg_sel      (cfg_sel),
    .cfg_en       (cfg_en),
    .cfg_busy     (cfg_busy),
    .cfg_done     (cfg_done),
    .cfg_drop     (cfg_drop),
    .test_clk_sel (test_clk_sel),
    .test_clk_en  (test_clk_en)
  );

  testchip_testclk_ctrl #(
    .DRAIN_CYCLES  (1),
    .SETTLE_CYCLES (1)
  ) u_dut_fast (
    .uc_clk       (uc_clk),
    .reset_n      (reset_n),
    .cfg_req      (req2),
    .cfg_sel      (sel2),
    .cfg_en       (en2),
    .cfg_busy     (busy2),
    .cfg_done     (done2),
    .cfg_drop     (drop2),
    .test_clk_sel (tsel2),
    .test_clk_en  (ten2)
  );

  initial uc_clk = 1'b0;
  always #5 uc_clk = ~uc_clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge uc_clk);
    #1;
  endtask

  task automatic send(input logic [3:0] s, input logic e);
    cfg_req = 1'b1;
    cfg_sel = s;
    cfg_en  = e;
    step();
    cfg_req = 1'b0;
  endtask

  task automatic send2(input logic [3:0] s, input logic e);
    req2 = 1'b1;
    sel2 = s;
    en2  = e;
    step();
    req2 = 1'b0;
  endtask

  // Select must never move while the gate is open or was open the cycle before.
  always begin
    @(posedge uc_clk);
    #1;
    if (mon_on) begin
      if (test_clk_sel != prev_sel && (test_clk_en || prev_en)) viol++;
      if (tsel2 != prev_sel2 && (ten2 || prev_en2)) viol++;
      if (cfg_done && cfg_drop) viol++;
      if (done2 && drop2) viol++;
      if (cfg_done) mon_dones++;
    end
    prev_sel  = test_clk_sel;
    prev_en   = test_clk_en;
    prev_sel2 = tsel2;
    prev_en2  = ten2;
  end

  initial begin
    int bad;
    int dones;
    int r;
    n_checks  = 0;
    n_errors  = 0;
    viol      = 0;
    mon_dones = 0;
    mon_on    = 1'b0;
    reset_n   = 1'b0;
    cfg_req   = 1'b0;
    cfg_sel   = 4'h0;
    cfg_en    = 1'b0;
    req2      = 1'b0;
    sel2      = 4'h0;
    en2       = 1'b0;

    repeat (3) step();
    check("rst_sel",  32'(test_clk_sel), 32'h0);
    check("rst_en",   32'(test_clk_en),  32'h0);
    check("rst_busy", 32'(cfg_busy),     32'h0);
    check("rst_done", 32'(cfg_done),     32'h0);
    check("rst_drop", 32'(cfg_drop),     32'h0);
    reset_n = 1'b1;
    repeat (6) step();

    // Full path to REF1 with default timing: T+1 gate off, T+17 switch, T+49 done.
    send(4'h3, 1'b1);
    check("t1_en_off",  32'(test_clk_en),  32'h0);
    check("t1_busy_on", 32'(cfg_busy),     32'h1);
    check("t1_sel_old", 32'(test_clk_sel), 32'h0);
    bad = 0;
    for (int i = 2; i <= 16; i++) begin
      step();
      if (!cfg_busy) bad++;
    end
    check("t1_sel_hold_t16", 32'(test_clk_sel), 32'h0);
    step();
    check("t1_sel_new_t17", 32'(test_clk_sel), 32'h3);
    check("t1_en_t17",      32'(test_clk_en),  32'h0);
    for (int i = 18; i <= 48; i++) begin
      step();
      if (!cfg_busy) bad++;
    end
    check("t1_busy_span", 32'(bad), 32'h0);
    check("t1_en_t48",   32'(test_clk_en), 32'h0);
    check("t1_done_t48", 32'(cfg_done),    32'h0);
    step();
    check("t1_en_t49",   32'(test_clk_en), 32'h1);
    check("t1_done_t49", 32'(cfg_done),    32'h1);
    check("t1_busy_t49", 32'(cfg_busy),    32'h0);
    step();
    check("t1_done_t50", 32'(cfg_done), 32'h0);

    // Fast path: same select, only the enable changes.
    send(4'h3, 1'b0);
    check("t2_en",   32'(test_clk_en),  32'h0);
    check("t2_done", 32'(cfg_done),     32'h1);
    check("t2_busy", 32'(cfg_busy),     32'h0);
    check("t2_sel",  32'(test_clk_sel), 32'h3);
    step();
    send(4'h3, 1'b1);
    check("t2b_en",   32'(test_clk_en), 32'h1);
    check("t2b_done", 32'(cfg_done),    32'h1);
    check("t2b_busy", 32'(cfg_busy),    32'h0);
    step();

    // Request while busy is dropped.
    send(4'h8, 1'b1);
    repeat (4) step();
    cfg_req = 1'b1;
    cfg_sel = 4'h6;
    cfg_en  = 1'b0;
    step();
    cfg_req = 1'b0;
    check("t3_drop_t6", 32'(cfg_drop), 32'h1);
    step();
    check("t3_drop_t7", 32'(cfg_drop), 32'h0);
    dones = 0;
    for (int i = 0; i < 60; i++) begin
      step();
      if (cfg_done) dones++;
    end
    check("t3_one_done", 32'(dones),        32'h1);
    check("t3_sel",      32'(test_clk_sel), 32'h8);
    check("t3_en",       32'(test_clk_en),  32'h1);

    // Reset during SETTLE of a switch to AUX1.
    send(4'h5, 1'b1);
    repeat (19) step();
    check("t4_sel_settle", 32'(test_clk_sel), 32'h5);
    check("t4_en_settle",  32'(test_clk_en),  32'h0);
    check("t4_busy",       32'(cfg_busy),     32'h1);
    #2;
    reset_n = 1'b0;
    #1;
    check("t4_rst_sel",  32'(test_clk_sel), 32'h0);
    check("t4_rst_en",   32'(test_clk_en),  32'h0);
    check("t4_rst_busy", 32'(cfg_busy),     32'h0);
    repeat (2) step();
    reset_n = 1'b1;
    dones = 0;
    for (int i = 0; i < 60; i++) begin
      step();
      if (cfg_done) dones++;
    end
    check("t4_no_done",   32'(dones),        32'h0);
    check("t4_sel_after", 32'(test_clk_sel), 32'h0);
    check("t4_en_after",  32'(test_clk_en),  32'h0);

    // Minimum timing instance: switch at T+2, done at T+3.
    send2(4'h2, 1'b1);
    check("t5_en_t1",   32'(ten2),  32'h0);
    check("t5_busy_t1", 32'(busy2), 32'h1);
    check("t5_sel_t1",  32'(tsel2), 32'h0);
    step();
    check("t5_sel_t2", 32'(tsel2), 32'h2);
    check("t5_en_t2",  32'(ten2),  32'h0);
    step();
    check("t5_en_t3",   32'(ten2),  32'h1);
    check("t5_done_t3", 32'(done2), 32'h1);
    check("t5_busy_t3", 32'(busy2), 32'h0);
    step();

    // Request landing on the SETTLE exit cycle is discarded.
    send2(4'h6, 1'b0);
    step();
    req2 = 1'b1;
    sel2 = 4'h4;
    en2  = 1'b1;
    step();
    req2 = 1'b0;
    check("t6_done",  32'(done2), 32'h1);
    check("t6_drop",  32'(drop2), 32'h0);
    check("t6_sel",   32'(tsel2), 32'h6);
    check("t6_en",    32'(ten2),  32'h0);
    step();
    check("t6_busy_after", 32'(busy2), 32'h0);
    check("t6_sel_after",  32'(tsel2), 32'h6);

    // Random back-to-back traffic on both instances under the invariant monitor.
    mon_on = 1'b1;
    for (int i = 0; i < 2000; i++) begin
      r       = $urandom_range(0, 3);
      cfg_req = (r == 0);
      r       = $urandom_range(0, 8);
      cfg_sel = 4'(r);
      r       = $urandom_range(0, 1);
      cfg_en  = r[0];
      r       = $urandom_range(0, 2);
      req2    = (r == 0);
      r       = $urandom_range(0, 8);
      sel2    = 4'(r);
      r       = $urandom_range(0, 1);
      en2     = r[0];
      step();
    end
    cfg_req = 1'b0;
    req2    = 1'b0;
    repeat (60) step();
    mon_on = 1'b0;
    check("rand_invariant", 32'(viol), 32'h0);
    check("rand_some_done", 32'(mon_dones > 10), 32'h1);
    check("rand_idle_busy", 32'(cfg_busy), 32'h0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/testchip_testclk_ctrl.md
Name: testchip_testclk_ctrl

Overview:
Glitch-safe sequencer that sits directly upstream of the test-clock select/gate stage and drives its test_clk_sel and test_clk_en inputs. Software (uc side) requests a new source select and enable. The block then performs the sequence: gate off, drain, switch select, settle, re-apply enable. This guarantees the select never changes while the downstream gate is open. It runs on uc_clk.

Parameters:
DRAIN_CYCLES, 16, uc_clk cycles test_clk_en is held low before test_clk_sel changes (legal range 1..255).
SETTLE_CYCLES, 32, uc_clk cycles after the select change before the enable is re-applied (legal range 1..255).

Ports:
uc_clk  input  1  block clock.
reset_n  input  1  asynchronous active-low reset.
cfg_req  input  1  single-cycle request strobe; samples cfg_sel and cfg_en.
cfg_sel  input  4  requested source code: 0000..0111 decoded sources, 1xxx phy test clock.
cfg_en  input  1  requested gate enable after the switch.
cfg_busy  output  1  sequence in progress.
cfg_done  output  1  one-cycle pulse when the requested state is applied.
cfg_drop  output  1  one-cycle pulse when cfg_req arrives while busy.
test_clk_sel  output  4  select to the test-clock mux stage.
test_clk_en  output  1  enable to the test-clock gating cell.

Behaviour:
- Reset values (asynchronous, active-low): test_clk_sel=4'b0000, test_clk_en=0, cfg_busy=0, cfg_done=0, cfg_drop=0, state IDLE, counter 0, shadow registers 0.
- States:
  - IDLE: waits for a request.
  - DRAIN: test_clk_en held at 0 while the counter runs.
  - SETTLE: new test_clk_sel driven, test_clk_en still 0.
  - Exit from SETTLE (or the fast path) drives test_clk_en=shadow_en, pulses cfg_done and returns to IDLE.
- In IDLE, cfg_req sampled at cycle T: cfg_sel and cfg_en are latched into shadow_sel and shadow_en.
- Fast path (shadow_sel == test_clk_sel): at T+1, test_clk_en=shadow_en and cfg_done=1. cfg_busy never asserts. State stays IDLE.
- Full path (select differs):
  - T+1: test_clk_en=0, cfg_busy=1, state DRAIN, counter loaded with DRAIN_CYCLES-1.
  - DRAIN covers cycles T+1..T+DRAIN_CYCLES.
  - T+DRAIN_CYCLES+1: test_clk_sel=shadow_sel, state SETTLE, counter loaded with SETTLE_CYCLES-1.
  - SETTLE covers cycles T+DRAIN_CYCLES+1..T+DRAIN_CYCLES+SETTLE_CYCLES.
  - T+DRAIN_CYCLES+SETTLE_CYCLES+1: test_clk_en=shadow_en, cfg_done=1, cfg_busy=0, state IDLE.
- The full path always drains, even if test_clk_en was already 0. Latency is therefore deterministic.
- test_clk_sel changes only on the DRAIN->SETTLE transition and only while test_clk_en=0. The verification bench asserts this invariant.
- cfg_req while cfg_busy=1: ignored. Shadow registers are unchanged. cfg_drop pulses for one cycle in the following cycle.
- cfg_req in the same cycle as the SETTLE exit: treated as busy and dropped. A new request is accepted from the cycle cfg_busy=0 is observed.
- Counter: 8-bit down-counter. A state transition fires when the counter is 0 and the counter is not decremented further. No wrap.
- Reset mid-sequence: immediate return to reset values. The gate ends closed with select 0000. No resumption of the interrupted sequence.
- cfg_done and cfg_drop are registered and mutually exclusive per cycle.
- Parameter values 0 or >255 are illegal. An elaboration-time check fails the build.

Decomposition:
- Shared package testchip_testclk_pkg:
  - State enum: IDLE, DRAIN, SETTLE.
  - Select code constants: TCLK_SEL_PAM3=4'b0000, TCLK_SEL_UC=4'b0001, TCLK_SEL_REF0=4'b0010, TCLK_SEL_REF1=4'b0011, TCLK_SEL_AUX0=4'b0100, TCLK_SEL_AUX1=4'b0101, TCLK_SEL_NOC=4'b0110, TCLK_SEL_CDB=4'b0111, TCLK_SEL_PHY=4'b1000.
  - Counter width constant TCLK_CNT_W=8.
- No sub-module. The counter and FSM stay inline in a single module.

Test Plan:
- Reset release, then cfg_req sel=0011 en=1 at cycle 10 (defaults) -> test_clk_en=0 at 11, test_clk_sel=0011 at 27, test_clk_en=1 and cfg_done=1 at 59, cfg_busy high 11..58.
- After the above, cfg_req sel=0011 en=0 -> next cycle test_clk_en=0 and cfg_done=1. cfg_busy stays 0. test_clk_sel is unchanged.
- cfg_req sel=1000 en=1, second cfg_req sel=0110 at T+5 -> cfg_drop pulse at T+6. Final test_clk_sel=1000. Only one cfg_done.
- reset_n asserted during SETTLE of a switch to 0101 -> outputs immediately test_clk_sel=0000, test_clk_en=0, cfg_busy=0. No cfg_done afterwards.
- Parameter override DRAIN_CYCLES=1, SETTLE_CYCLES=1, request at T -> select changes at T+2, enable/done at T+3.
- Randomized back-to-back requests -> assertion: test_clk_sel never changes in a cycle where test_clk_en=1 or where test_clk_en was 1 in the prior cycle.
